// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// State encoding, port indices, full-word byte-enable constant and the RMW byte merge.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Overlay the enabled byte lanes of new_word onto old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] word;
    word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        word[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
// The requester uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_be,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_be,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way grant with a last-grant register; alternates between ports on contention.
// Defining DMEM_ARB_FIXED_PRIO_EN makes port 0 win every contended cycle instead.
module dmem_rr_arb
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  // Grant is combinational from the request vector so ready can follow valid in the same cycle.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          grant = 2'b01;
`else
          grant = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
`endif
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Resetting to the debug port means the core port wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DBG;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for a 256x32 word memory; partial stores become read-modify-write.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in the grant logic.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t state;
  state_t state_next;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       accept;
  logic       gport;

  logic              sel_we;
  logic [3:0]        sel_be;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              is_partial;
  logic              rmw_start;

  logic [DATA_W-1:0] merge_q;
  logic [31:0]       rmw_addr;
  logic              rmw_port;

  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_err;
  logic [1:0][DATA_W-1:0] rsp_rdata;

  assign valid = {p1.req_valid, p0.req_valid};

  dmem_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (state == IDLE),
    .req    (valid),
    .grant  (grant)
  );

  assign accept = |grant;
  assign gport  = grant[1];

  assign p0.req_ready = grant[0];
  assign p1.req_ready = grant[1];

  assign sel_we    = gport ? p1.req_we    : p0.req_we;
  assign sel_be    = gport ? p1.req_be    : p0.req_be;
  assign sel_addr  = gport ? p1.req_addr  : p0.req_addr;
  assign sel_wdata = gport ? p1.req_wdata : p0.req_wdata;

  assign in_range   = ({2'b00, sel_addr[31:2]} < 32'(MEM_WORDS));
  assign is_partial = sel_we && (sel_be != 4'h0) && (sel_be != BE_FULL);
  assign rmw_start  = (state == IDLE) && accept && in_range && is_partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory strobes only fire in an accepting cycle or during the RMW write-back.
  always_comb begin
    state_next   = state;
    mem_addr     = 32'h0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && in_range) begin
          if (!sel_we) begin
            mem_addr    = sel_addr;
            mem_read_en = 1'b1;
          end else if (sel_be == BE_FULL) begin
            mem_addr     = sel_addr;
            mem_write_en = 1'b1;
            mem_data_in  = sel_wdata;
          end else if (sel_be != 4'h0) begin
            mem_addr    = sel_addr;
            mem_read_en = 1'b1;
            state_next  = RMW;
          end
        end
      end
      RMW: begin
        mem_addr     = rmw_addr;
        mem_data_in  = merge_q;
        mem_write_en = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Responses are registered one cycle after the accept, or after the RMW write for partial stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_q   <= '0;
      rmw_addr  <= 32'h0;
      rmw_port  <= PORT_CORE;
      rsp_valid <= 2'b00;
      rsp_err   <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 2'b00;
      rsp_err   <= 2'b00;
      if (rmw_start) begin
        merge_q  <= merge_bytes(mem_data_out, sel_wdata, sel_be);
        rmw_addr <= sel_addr;
        rmw_port <= gport;
      end
      if (state == RMW) begin
        rsp_valid[rmw_port] <= 1'b1;
        rsp_rdata[rmw_port] <= '0;
      end else if (accept && !rmw_start) begin
        rsp_valid[gport] <= 1'b1;
        rsp_err[gport]   <= !in_range;
        rsp_rdata[gport] <= (!sel_we && in_range) ? mem_data_out : '0;
      end
    end
  end

  assign p0.rsp_valid = rsp_valid[0];
  assign p0.rsp_err   = rsp_err[0];
  assign p0.rsp_rdata = rsp_rdata[0];
  assign p1.rsp_valid = rsp_valid[1];
  assign p1.rsp_err   = rsp_err[1];
  assign p1.rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a response scoreboard.
// Grant expectations follow DMEM_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_dmem_arbiter;

  typedef struct {
    logic        valid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_data_out;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rsp_t q0[$];
  rsp_t q1[$];

  logic        model_rmw  = 1'b0;
  logic        model_last = 1'b1;
  logic [31:0] pend_word;
  logic [31:0] pend_addr;

  dmem_arbiter_if p0_if ();
  dmem_arbiter_if p1_if ();

  dmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p0           (p0_if),
    .p1           (p1_if),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: combinational read gated by read enable, synchronous write.
  assign mem_data_out = mem_read_en ? mem[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[9:2]] <= mem_data_in;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.valid = v;
    r.we    = we;
    r.be    = be;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  // Each falling edge: a due scoreboard entry must appear on its port, otherwise rsp_valid stays low.
  always @(negedge clk) begin
    rsp_t e;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      check_output("p0_rsp_valid", p0_if.rsp_valid, 32'h1);
      check_output("p0_rsp_rdata", p0_if.rsp_rdata, e.rdata);
      check_output("p0_rsp_err", p0_if.rsp_err, e.err);
    end else begin
      check_output("p0_rsp_quiet", p0_if.rsp_valid, 32'h0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      check_output("p1_rsp_valid", p1_if.rsp_valid, 32'h1);
      check_output("p1_rsp_rdata", p1_if.rsp_rdata, e.rdata);
      check_output("p1_rsp_err", p1_if.rsp_err, e.err);
    end else begin
      check_output("p1_rsp_quiet", p1_if.rsp_valid, 32'h0);
    end
  end

  // Drive one cycle of requests at a falling edge, check ready/strobes, and queue expected responses.
  task automatic apply_stimulus(input req_t r0, input req_t r1);
    logic [1:0]  exp_g;
    logic        port;
    logic        inr;
    logic [7:0]  idx;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] word;
    req_t        r;
    rsp_t        e;

    p0_if.req_valid = r0.valid;
    p0_if.req_we    = r0.we;
    p0_if.req_be    = r0.be;
    p0_if.req_addr  = r0.addr;
    p0_if.req_wdata = r0.wdata;
    p1_if.req_valid = r1.valid;
    p1_if.req_we    = r1.we;
    p1_if.req_be    = r1.be;
    p1_if.req_addr  = r1.addr;
    p1_if.req_wdata = r1.wdata;
    #1;

    exp_g  = 2'b00;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (!model_rmw) begin
      case ({r1.valid, r0.valid})
        2'b01: exp_g = 2'b01;
        2'b10: exp_g = 2'b10;
        2'b11: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          exp_g = 2'b01;
`else
          exp_g = model_last ? 2'b01 : 2'b10;
`endif
        end
        default: exp_g = 2'b00;
      endcase
    end
    check_output("p0_ready", p0_if.req_ready, exp_g[0]);
    check_output("p1_ready", p1_if.req_ready, exp_g[1]);

    if (model_rmw) begin
      exp_wr = 1'b1;
      check_output("rmw_addr", mem_addr, pend_addr);
      check_output("rmw_wdata", mem_data_in, pend_word);
      ref_mem[pend_addr[9:2]] = pend_word;
      model_rmw = 1'b0;
    end else if (exp_g != 2'b00) begin
      port       = exp_g[1];
      r          = port ? r1 : r0;
      model_last = port;
      inr        = (r.addr[31:10] == 22'h0);
      idx        = r.addr[9:2];
      e.rdata    = 32'h0;
      e.err      = !inr;
      e.due      = cyc + 1;
      if (inr) begin
        if (!r.we) begin
          exp_rd  = 1'b1;
          e.rdata = ref_mem[idx];
        end else if (r.be == 4'hF) begin
          exp_wr = 1'b1;
          check_output("store_wdata", mem_data_in, r.wdata);
          ref_mem[idx] = r.wdata;
        end else if (r.be != 4'h0) begin
          exp_rd = 1'b1;
          word   = ref_mem[idx];
          for (int b = 0; b < 4; b++) begin
            if (r.be[b]) word[8*b +: 8] = r.wdata[8*b +: 8];
          end
          pend_word = word;
          pend_addr = r.addr;
          model_rmw = 1'b1;
          e.due     = cyc + 2;
        end
        if (exp_rd || exp_wr) check_output("mem_addr", mem_addr, r.addr);
      end
      if (port) q1.push_back(e);
      else      q0.push_back(e);
    end
    check_output("mem_read_en", mem_read_en, exp_rd);
    check_output("mem_write_en", mem_write_en, exp_wr);
    @(negedge clk);
  endtask

  initial begin
    req_t idle;
    idle = mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5A5A0000 | i;
      ref_mem[i] = 32'h5A5A0000 | i;
    end
    mem[4]     = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    mem[8]     = 32'h11223344;
    ref_mem[8] = 32'h11223344;

    p0_if.req_valid = 1'b0; p0_if.req_we = 1'b0; p0_if.req_be = 4'h0;
    p0_if.req_addr  = 32'h0; p0_if.req_wdata = 32'h0;
    p1_if.req_valid = 1'b0; p1_if.req_we = 1'b0; p1_if.req_be = 4'h0;
    p1_if.req_addr  = 32'h0; p1_if.req_wdata = 32'h0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset_p0_rdata", p0_if.rsp_rdata, 32'h0);
    check_output("reset_p1_rdata", p1_if.rsp_rdata, 32'h0);
    check_output("reset_p0_err", p0_if.rsp_err, 32'h0);
    check_output("reset_p1_err", p1_if.rsp_err, 32'h0);
    check_output("reset_wen", mem_write_en, 32'h0);
    check_output("reset_ren", mem_read_en, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single load from port 0");
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h10, 32'h0), idle);
    apply_stimulus(idle, idle);

    $display("[TB] contention on four consecutive cycles");
    repeat (4) apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h10, 32'h0),
                              mk(1'b1, 1'b0, 4'h0, 32'h3FC, 32'h0));

    $display("[TB] partial store then load of the merged word");
    apply_stimulus(idle, mk(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00));
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h20, 32'h0), idle);
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h20, 32'h0), idle);
    check_output("rmw_mem_word", mem[8], 32'h1122AB44);

    $display("[TB] full store then load back-to-back");
    apply_stimulus(mk(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D), idle);
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h30, 32'h0), idle);

    $display("[TB] out-of-range and empty byte-enable accesses");
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h400, 32'h0), idle);
    apply_stimulus(idle, mk(1'b1, 1'b1, 4'hF, 32'h404, 32'h12345678));
    apply_stimulus(idle, mk(1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF));
    apply_stimulus(idle, mk(1'b1, 1'b0, 4'h0, 32'h30, 32'h0));
    apply_stimulus(idle, idle);

    $display("[TB] reset during the read-modify-write cycle");
    apply_stimulus(mk(1'b1, 1'b1, 4'b1000, 32'h40, 32'hAA000000), idle);
    p0_if.req_valid = 1'b0;
    #1;
    check_output("rmw_wen_before_reset", mem_write_en, 32'h1);
    rst = 1'b1;
    #1;
    check_output("rmw_wen_in_reset", mem_write_en, 32'h0);
    check_output("reset_rdata_cleared", p0_if.rsp_rdata, 32'h0);
    q0.delete();
    q1.delete();
    model_rmw  = 1'b0;
    model_last = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rmw_dropped_word", mem[16], ref_mem[16]);
    apply_stimulus(mk(1'b1, 1'b0, 4'h0, 32'h40, 32'h0), mk(1'b1, 1'b0, 4'h0, 32'h44, 32'h0));
    apply_stimulus(idle, idle);
    apply_stimulus(idle, idle);

    check_output("scoreboard_drained", q0.size() + q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller in front of the word-addressed data memory (256 x 32, synchronous write, combinational read with read enable).
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Arbitrates with valid/ready and returns a one-cycle response pulse.
- Turns partial (byte-enable) stores into a two-cycle read-modify-write, because the memory writes whole words only.

Parameters:
- MEM_WORDS, 256: number of 32-bit words; a word index addr[31:2] >= MEM_WORDS is out of range.
- DATA_W, 32: data width; fixed at 32, byte enables are DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req_valid / p1_req_valid  in  1  request valid.
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle when high together with valid.
- p0_req_we / p1_req_we  in  1  1 = store, 0 = load.
- p0_req_be / p1_req_be  in  4  byte enables for stores; ignored for loads.
- p0_req_addr / p1_req_addr  in  32  byte address; bits [1:0] ignored.
- p0_req_wdata / p1_req_wdata  in  32  store data, byte lanes aligned.
- p0_rsp_valid / p1_rsp_valid  out  1  single-cycle completion pulse; no backpressure.
- p0_rsp_rdata / p1_rsp_rdata  out  32  load data, valid with rsp_valid.
- p0_rsp_err / p1_rsp_err  out  1  out-of-range access, valid with rsp_valid.
- mem_addr  out  32  memory address.
- mem_data_in  out  32  memory write data.
- mem_write_en  out  1  memory write enable.
- mem_read_en  out  1  memory read enable.
- mem_data_out  in  32  memory combinational read data.

Behaviour:
- FSM states: IDLE, RMW.
- Reset, asynchronous: state=IDLE, last_grant=1 (port 0 wins first), all rsp_valid/rsp_err=0, rsp_rdata=0, merge register=0. Memory enables are 0 whenever not in an accepting cycle.
- IDLE arbitration:
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port != last_grant.
  - Only the granted port sees req_ready=1; ready is combinational from valid.
  - last_grant updates on every accept.
- Load (accept in IDLE):
  - mem_addr=req_addr, mem_read_en=1 in the accept cycle.
  - mem_data_out is registered into the granted port's rsp_rdata.
  - rsp_valid=1 the following cycle. Latency 1; throughput 1 per cycle.
- Full store, be=4'hF: mem_write_en=1 and mem_data_in=wdata in the accept cycle; ack rsp_valid next cycle; rdata=0.
- Partial store, be!=0 and be!=F:
  - Accept cycle: mem_read_en=1; register merged word = be-selected wdata bytes over mem_data_out, plus the address and the port; go to RMW.
  - RMW cycle: mem_write_en=1 with the registered address/data; both req_ready=0; return to IDLE.
  - rsp_valid pulses the cycle after the RMW write. Latency 2; no accept during RMW.
- be=0 store: no memory access; ack next cycle.
- Out of range: no memory enable asserted, no RMW; rsp_valid and rsp_err=1 next cycle; rdata=0.
- rsp_valid is 0 for every cycle that is not a completion. rsp_rdata holds its last value.
- Reset mid-RMW: the pending write is dropped and no response is issued.
- Back-to-back accesses: a load of the same word right after an RMW sees the merged data, because the write completes before the next accept.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both ports are valid; last_grant is unused (reset value still 1, harmless).
- Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, RMW};
  - port index constants PORT_CORE=0, PORT_DBG=1;
  - BE_FULL=4'hF;
  - byte-merge function (old word, new word, be) -> word.
- One sub-module: dmem_rr_arb, a 2-way round-robin grant with last_grant register; fixed-priority mode is selected by the macro inside it.

Test Plan:
- Reset then port 0 load at 0x10, memory word 0xDEADBEEF -> ready same cycle; p0_rsp_valid=1 with rdata 0xDEADBEEF next cycle.
- Both ports valid for 4 consecutive cycles, full-word loads -> grants alternate 0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN -> 0,0,0,0 and p1 starved.
- Word 0x11223344 at 0x20; port 1 store be=4'b0010, wdata=0x0000AB00 -> write_en in cycle 2 only; rsp at cycle 3; subsequent load returns 0x1122AB44.
- Port 0 store be=4'hF, then immediate port 0 load of the same address -> load returns the stored word; 1 response per cycle.
- Load at 0x400 (word 256, MEM_WORDS=256) -> no mem enables; rsp_valid=1, rsp_err=1, rdata=0.
- Assert rst during the RMW cycle -> mem_write_en deasserts immediately, memory unchanged, no rsp_valid, next grant goes to port 0.
